rgb2y_seq: RTL and testbench

Sequencer for the RGB-to-luma stage of the face-detection front end. Accepts one RGB pixel per valid/ready handshake and drives a single shared constant multiplier across the R, G and B coefficients over three cycles. It accumulates the Q16 products and presents an 8-bit luma sample with valid/ready backpressure. The block sits between the camera pixel unpacker and the skin/grayscale window buffers, and replaces three per-channel multiplier blocks with one time-shared unit.

---
 rtl/rgb2y_seq.sv | 136 +++++++++++++
 tb/tb_rgb2y_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2y_seq.sv
// RGB-to-luma sequencer: one pixel per handshake, one shared 8x16 multiplier
// stepped across R, G and B, Q16 accumulate, registered 8-bit luma output.
//
// state  | meaning
// IDLE   | waiting for a pixel, oReady high unless flushing
// MUL_R  | acc += R * COEF_R
// MUL_G  | acc += G * COEF_G
// MUL_B  | acc += B * COEF_B, luma/tag registered
// OUT    | oValid high, hold until iReady
module rgb2y_seq #(
    parameter logic [15:0] COEF_R = 16'd19595,
    parameter logic [15:0] COEF_G = 16'd38470,
    parameter logic [15:0] COEF_B = 16'd7470,
    parameter int          TAG_W  = 4
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [7:0]       iR,
    input  logic [7:0]       iG,
    input  logic [7:0]       iB,
    input  logic [TAG_W-1:0] iTag,
    input  logic             iFlush,
    output logic             oValid,
    input  logic             iReady,
    output logic [7:0]       oY,
    output logic [TAG_W-1:0] oTag,
    output logic             oBusy
);

    // coefficient sum bounds the accumulator at 255 * 65535, which fits 24 bits
    if (32'(COEF_R) + 32'(COEF_G) + 32'(COEF_B) > 32'd65535) begin : g_coef_sum_chk
        $error("rgb2y_seq: COEF_R + COEF_G + COEF_B exceeds 65535");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL_R = 3'd1,
        S_MUL_G = 3'd2,
        S_MUL_B = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_r, r_g, r_b;
    logic [TAG_W-1:0]   r_tag;
    logic [23:0]        r_acc;
    logic [7:0]         r_y;
    logic [TAG_W-1:0]   r_tag_out;
    logic [7:0]         w_chan;
    logic [15:0]        w_coef;
    logic [23:0]        w_prod;
    logic [23:0]        w_acc_sum;
    logic               w_accept;

    assign oReady    = iReset_n && (r_state == S_IDLE) && !iFlush;
    assign w_accept  = oReady && iValid;
    assign oValid    = (r_state == S_OUT);
    assign oBusy     = (r_state != S_IDLE);
    assign oY        = r_y;
    assign oTag      = r_tag_out;

    // the single shared multiplier; operands selected by state
    always_comb begin
        w_chan = r_r;
        w_coef = COEF_R;
        case (r_state)
            S_MUL_G: begin
                w_chan = r_g;
                w_coef = COEF_G;
            end
            S_MUL_B: begin
                w_chan = r_b;
                w_coef = COEF_B;
            end
            default: ;
        endcase
    end

    assign w_prod    = {16'd0, w_chan} * {8'd0, w_coef};
    assign w_acc_sum = r_acc + w_prod;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_MUL_R;
            S_MUL_R: w_next = S_MUL_G;
            S_MUL_G: w_next = S_MUL_B;
            S_MUL_B: w_next = S_OUT;
            S_OUT:   if (iReady) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (iFlush) w_next = S_IDLE;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_tag     <= '0;
            r_acc     <= '0;
            r_y       <= '0;
            r_tag_out <= '0;
        end else if (iFlush) begin
            r_acc <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_r   <= iR;
                        r_g   <= iG;
                        r_b   <= iB;
                        r_tag <= iTag;
                        r_acc <= '0;
                    end
                end
                S_MUL_R, S_MUL_G: r_acc <= w_acc_sum;
                S_MUL_B: begin
                    r_acc     <= w_acc_sum;
                    r_y       <= w_acc_sum[23:16];
                    r_tag_out <= r_tag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb2y_seq.sv
// Bench for rgb2y_seq: directed vector table, backpressure, flush and reset
// sequences, and a random back-to-back stream checked against a luma model.
module tb_rgb2y_seq;

    logic       iClk = 1'b0;
    logic       iReset_n;
    logic       iValid;
    logic       oReady;
    logic [7:0] iR, iG, iB;
    logic [3:0] iTag;
    logic       iFlush;
    logic       oValid;
    logic       iReady;
    logic [7:0] oY;
    logic [3:0] oTag;
    logic       oBusy;

    rgb2y_seq #(.TAG_W(4)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iValid(iValid), .oReady(oReady),
        .iR(iR), .iG(iG), .iB(iB), .iTag(iTag), .iFlush(iFlush),
        .oValid(oValid), .iReady(iReady), .oY(oY), .oTag(oTag), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] r, g, b;
        logic [3:0] tag;
        logic [7:0] exp_y;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic [3:0] tag;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    function automatic logic [7:0] luma(input int r, input int g, input int b);
        int s;
        s = r * 19595 + g * 38470 + b * 7470;
        return 8'(s >>> 16);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // drives a pixel and returns just after the edge that accepted it
    task automatic accept_pixel(input logic [7:0] r, g, b, input logic [3:0] t,
                                input bit hold);
        int k;
        iR = r; iG = g; iB = b; iTag = t; iValid = 1'b1;
        k = 0;
        while (!oReady && k < 50) begin
            tick();
            k++;
        end
        chk("accept_ready", int'(oReady), 1);
        tick();
        if (!hold) iValid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!oValid && k < 30) begin
            tick();
            k++;
        end
        chk("valid_seen", int'(oValid), 1);
    endtask

    // output-side scoreboard for the streaming phase
    always @(negedge iClk) begin
        if (mon_en && oValid && iReady) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL stream_extra: unexpected sample y=%0d tag=%0d", oY, oTag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("stream_y", int'(oY), int'(e.y));
                chk("stream_tag", int'(oTag), int'(e.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   k;
        logic [7:0] ry, rg, rb;
        logic [7:0] hy;
        logic [3:0] ht;
        int   acc_cyc[8];

        tbl[0] = '{8'd255, 8'd255, 8'd255, 4'h5, 8'hFE};
        tbl[1] = '{8'd0,   8'd0,   8'd255, 4'h1, 8'h1D};
        tbl[2] = '{8'd255, 8'd0,   8'd0,   4'h2, 8'h4C};
        tbl[3] = '{8'd0,   8'd128, 8'd0,   4'h3, 8'h4B};

        iReset_n = 1'b0; iValid = 1'b0; iFlush = 1'b0; iReady = 1'b1;
        iR = '0; iG = '0; iB = '0; iTag = '0;
        #12;
        chk("rst_ready", int'(oReady), 0);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_y", int'(oY), 0);
        chk("rst_tag", int'(oTag), 0);
        chk("rst_busy", int'(oBusy), 0);
        @(negedge iClk);
        iReset_n = 1'b1;
        #1;
        chk("post_rst_ready", int'(oReady), 1);
        tick();

        // directed vectors
        for (int i = 0; i < 4; i++) begin
            accept_pixel(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].tag, 1'b0);
            chk("busy_after_accept", int'(oBusy), 1);
            chk("ready_low_busy", int'(oReady), 0);
            wait_valid(k);
            chk("latency", k, 3);
            chk("vec_y", int'(oY), int'(tbl[i].exp_y));
            chk("vec_tag", int'(oTag), int'(tbl[i].tag));
            tick();
            chk("valid_drop", int'(oValid), 0);
            chk("idle_ready", int'(oReady), 1);
        end

        // backpressure: hold OUT for 10 cycles with a second pixel waiting
        iReady = 1'b0;
        accept_pixel(8'd100, 8'd50, 8'd200, 4'h7, 1'b0);
        wait_valid(k);
        iR = 8'd10; iG = 8'd20; iB = 8'd30; iTag = 4'h9; iValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", int'(oValid), 1);
            chk("bp_y", int'(oY), int'(luma(100, 50, 200)));
            chk("bp_tag", int'(oTag), 7);
            chk("bp_ready", int'(oReady), 0);
        end
        iReady = 1'b1;
        tick();
        chk("bp_release_idle", int'(oBusy), 0);
        tick();
        chk("bp_second_accept", int'(oBusy), 1);
        iValid = 1'b0;
        wait_valid(k);
        chk("bp_second_lat", k, 3);
        chk("bp_second_y", int'(oY), int'(luma(10, 20, 30)));
        chk("bp_second_tag", int'(oTag), 9);
        tick();

        // random back-to-back stream with iValid held high
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ry = 8'($urandom_range(0, 255));
            rg = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            exp_q.push_back('{luma(int'(ry), int'(rg), int'(rb)), 4'(i + 3)});
            accept_pixel(ry, rg, rb, 4'(i + 3), 1'b1);
            acc_cyc[i] = cyc;
            if (i > 0) chk("stream_spacing", acc_cyc[i] - acc_cyc[i-1], 5);
        end
        iValid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            tick();
            k++;
        end
        tick();
        chk("stream_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // flush during MUL_G drops the pixel
        accept_pixel(8'd200, 8'd200, 8'd200, 4'hA, 1'b0);
        tick();
        iFlush = 1'b1;
        #1;
        chk("flush_ready_low", int'(oReady), 0);
        tick();
        chk("flush_idle", int'(oBusy), 0);
        chk("flush_no_valid", int'(oValid), 0);
        iFlush = 1'b0;
        #1;
        chk("flush_ready_back", int'(oReady), 1);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (oValid) k++;
        end
        chk("flush_no_pulse", k, 0);
        accept_pixel(8'd17, 8'd99, 8'd240, 4'hB, 1'b0);
        wait_valid(k);
        chk("flush_next_lat", k, 3);
        chk("flush_next_y", int'(oY), int'(luma(17, 99, 240)));
        chk("flush_next_tag", int'(oTag), 11);
        tick();

        // async reset mid MUL_B
        accept_pixel(8'd90, 8'd180, 8'd45, 4'hC, 1'b0);
        tick();
        tick();
        chk("pre_rst_busy", int'(oBusy), 1);
        #3;
        iReset_n = 1'b0;
        #1;
        chk("arst_ready", int'(oReady), 0);
        chk("arst_valid", int'(oValid), 0);
        chk("arst_busy", int'(oBusy), 0);
        chk("arst_y", int'(oY), 0);
        chk("arst_tag", int'(oTag), 0);
        @(negedge iClk);
        iReset_n = 1'b1;
        tick();
        accept_pixel(8'd33, 8'd66, 8'd99, 4'hD, 1'b0);
        wait_valid(k);
        chk("arst_next_lat", k, 3);
        chk("arst_next_y", int'(oY), int'(luma(33, 66, 99)));
        chk("arst_next_tag", int'(oTag), 13);
        tick();
        chk("arst_next_drop", int'(oValid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
